// File: rtl/profiler_pkg.sv
// profiler_pkg
// Shared definitions for the profile readout scheduler:
//   - state_e    : readout FSM states
//   - CNT_W      : width of every profiling counter / stream word
//   - HDR_MAGIC  : marker byte at the top of each unit header word
//   - sat_inc()  : saturating 32-bit increment
//   - hdr_word() : assembles a unit header word
package profiler_pkg;

  localparam int unsigned CNT_W     = 32;
  localparam logic [7:0]  HDR_MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNAP,
    ST_HDR,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_LAST
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // {magic, 4'h0, unit, counters-per-unit, frame sequence}
  function automatic logic [CNT_W-1:0] hdr_word(input logic [3:0] unit,
                                                input logic [7:0] cnt,
                                                input logic [7:0] seq);
    return {HDR_MAGIC, 4'h0, unit, cnt, seq};
  endfunction

endpackage

// File: rtl/profile_interval_timer.sv
// profile_interval_timer
// Free-running interval counter 0..INTERVAL-1 that requests a snapshot.
// Ports:
//   clk     in  : clock
//   rst_n   in  : asynchronous active-low reset
//   enable  in  : count when high; counter is held at 0 when low
//   expiry  out : high for the single cycle in which the counter is INTERVAL-1
module profile_interval_timer #(
  parameter int unsigned INTERVAL = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic expiry
);

  localparam int unsigned TW = $clog2(INTERVAL);

  logic [TW-1:0] timer_q, timer_d;

  assign expiry = (timer_q == TW'(INTERVAL - 1));

  always_comb begin
    timer_d = timer_q;
    if (!enable) begin
      timer_d = '0;
    end else if (expiry) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/profile_readout_scheduler.sv
// profile_readout_scheduler
// Periodically freezes the profiling units' counters and streams them out as
// one frame: per participating unit a header word followed by its counters.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   enable                : run timer and scheduling
//   unit_en[NUM_UNITS]    : units participating in the next frame
//   snapshot              : one-cycle freeze strobe to the units
//   rd_unit, rd_idx       : counter read address (non-zero only in RD_ADDR)
//   rd_data               : counter value, valid one cycle after the address
//   out_valid/out_ready/out_data/out_last : readout stream
//   busy                  : a frame is in progress
//   overrun_count         : snapshots skipped because a frame was draining
module profile_readout_scheduler
  import profiler_pkg::*;
#(
  parameter int unsigned INTERVAL     = 1000000,
  parameter int unsigned NUM_UNITS    = 4,
  parameter int unsigned CNT_PER_UNIT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NUM_UNITS-1:0] unit_en,
  output logic                 snapshot,
  output logic [3:0]           rd_unit,
  output logic [7:0]           rd_idx,
  input  logic [CNT_W-1:0]     rd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic [CNT_W-1:0]     overrun_count
);

  state_e               state_q, state_d;
  logic [NUM_UNITS-1:0] pending_q, pending_d;
  logic [7:0]           idx_q, idx_d;
  logic [7:0]           seq_q, seq_d;
  logic [3:0]           start_ptr_q, start_ptr_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic [CNT_W-1:0]     out_data_q, out_data_d;
  logic [CNT_W-1:0]     overrun_q, overrun_d;

  logic                 expiry;
  logic                 sel_found;
  logic [3:0]           sel_unit;
  logic [NUM_UNITS-1:0] sel_mask;
  logic                 last_idx;
  logic                 last_unit;

  profile_interval_timer #(
    .INTERVAL (INTERVAL)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .expiry (expiry)
  );

  // Round-robin pick: first pass looks at start_ptr and above, second pass
  // wraps to the lowest pending unit below start_ptr.
  always_comb begin
    sel_found = 1'b0;
    sel_unit  = start_ptr_q;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (!sel_found && (4'(u) >= start_ptr_q) && pending_q[u]) begin
        sel_found = 1'b1;
        sel_unit  = 4'(u);
      end
    end
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (!sel_found && pending_q[u]) begin
        sel_found = 1'b1;
        sel_unit  = 4'(u);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_sel_mask
    assign sel_mask[gi] = (sel_unit == 4'(gi));
  end

  assign last_idx  = (idx_q == 8'(CNT_PER_UNIT - 1));
  // The current unit is the last one of the frame when nothing else is pending.
  assign last_unit = ((pending_q & ~sel_mask) == '0);

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    idx_d       = idx_q;
    seq_d       = seq_q;
    start_ptr_d = start_ptr_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    overrun_d   = overrun_q;
    snapshot    = 1'b0;

    if (expiry && (state_q != ST_IDLE)) begin
      overrun_d = sat_inc(overrun_q);
    end

    case (state_q)
      ST_IDLE: begin
        if (expiry && (unit_en != '0)) begin
          snapshot = 1'b1;
          state_d  = ST_SNAP;
        end
      end
      ST_SNAP: begin
        pending_d = unit_en;
        idx_d     = '0;
        state_d   = (unit_en != '0) ? ST_HDR : ST_IDLE;
      end
      // HDR and RD_WAIT share a two-phase pattern: load the word and raise
      // out_valid, then hold it until the handshake.
      ST_HDR: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          out_data_d  = hdr_word(sel_unit, 8'(CNT_PER_UNIT), seq_q);
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = rd_data;
          out_last_d  = last_idx && last_unit;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (last_idx) begin
            idx_d     = '0;
            pending_d = pending_q & ~sel_mask;
            state_d   = out_last_q ? ST_LAST : ST_HDR;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = ST_RD_ADDR;
          end
        end
      end
      ST_LAST: begin
        seq_d       = seq_q + 8'd1;
        start_ptr_d = (start_ptr_q == 4'(NUM_UNITS - 1)) ? 4'd0 : start_ptr_q + 4'd1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      idx_q       <= '0;
      seq_q       <= '0;
      start_ptr_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      overrun_q   <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      idx_q       <= idx_d;
      seq_q       <= seq_d;
      start_ptr_q <= start_ptr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rd_unit       = (state_q == ST_RD_ADDR) ? sel_unit : 4'd0;
  assign rd_idx        = (state_q == ST_RD_ADDR) ? idx_q : 8'd0;
  assign busy          = (state_q != ST_IDLE);
  assign out_valid     = out_valid_q;
  assign out_last      = out_last_q;
  assign out_data      = out_data_q;
  assign overrun_count = overrun_q;

endmodule

// File: tb/tb_profile_readout_scheduler.sv
// Scoreboard bench: directed scenarios push expected stream words and
// snapshot cycles into queues; a monitor pops and compares on every
// transfer / snapshot pulse.
module tb_profile_readout_scheduler;

  localparam int unsigned INTERVAL = 64;
  localparam int unsigned NU       = 2;
  localparam int unsigned CPU      = 2;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic [NU-1:0] unit_en;
  logic          snapshot;
  logic [3:0]    rd_unit;
  logic [7:0]    rd_idx;
  logic [31:0]   rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          out_last;
  logic          busy;
  logic [31:0]   overrun_count;

  profile_readout_scheduler #(
    .INTERVAL     (INTERVAL),
    .NUM_UNITS    (NU),
    .CNT_PER_UNIT (CPU)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .unit_en       (unit_en),
    .snapshot      (snapshot),
    .rd_unit       (rd_unit),
    .rd_idx        (rd_idx),
    .rd_data       (rd_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .busy          (busy),
    .overrun_count (overrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter memory model: counter value = unit*16 + idx, one cycle latency.
  always @(posedge clk) rd_data <= 32'(rd_unit) * 32'd16 + 32'(rd_idx);

  // Cycle number since reset release; equals the DUT timer while enabled.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic [32:0] exp_q[$];
  int          snap_q[$];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
  endtask

  // Monitor
  logic        hold_v = 1'b0;
  logic [32:0] hold_w = '0;
  logic [32:0] mon_w;
  int          mon_c;
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_word", 64'({out_last, out_data}), 64'(hold_w));
      end
      if (out_valid && out_ready) begin
        $display("cyc %0d word %08h last %0b", cyc, out_data, out_last);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL stream_extra: got %08h, expected no word", out_data);
        end else begin
          mon_w = exp_q.pop_front();
          check("stream_word", 64'({out_last, out_data}), 64'(mon_w));
        end
      end
      if (snapshot) begin
        $display("cyc %0d snapshot", cyc);
        if (snap_q.size() == 0) begin
          n_checks++;
          $display("FAIL snapshot_extra: got pulse at cyc %0d, expected none", cyc);
        end else begin
          mon_c = snap_q.pop_front();
          check("snapshot_cycle", 64'(cyc), 64'(mon_c));
        end
      end
      hold_v = out_valid && !out_ready;
      hold_w = {out_last, out_data};
    end
  end

  task automatic check_idle(string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_data"},  64'(out_data),  64'd0);
    check({tag, "_out_last"},  64'(out_last),  64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_snapshot"},  64'(snapshot),  64'd0);
    check({tag, "_rd_unit"},   64'(rd_unit),   64'd0);
    check({tag, "_rd_idx"},    64'(rd_idx),    64'd0);
    check({tag, "_overrun"},   64'(overrun_count), 64'd0);
  endtask

  task automatic do_reset(string tag);
    rst_n = 1'b0;
    enable = 1'b1;
    out_ready = 1'b1;
    exp_q.delete();
    snap_q.delete();
    #1;
    check_idle({tag, "_reset"});
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_cyc(int n);
    int guard = 0;
    while (cyc < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      n_checks++;
      $display("FAIL wait_cyc: got cyc %0d, expected %0d", cyc, n);
    end
  endtask

  task automatic end_test(string tag);
    check({tag, "_stream_left"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_snap_left"},   64'(snap_q.size()), 64'd0);
  endtask

  task automatic push(logic last, logic [31:0] w);
    exp_q.push_back({last, w});
  endtask

  initial begin
    unit_en = 2'b11;
    enable  = 1'b1;

    // 1: basic frame, both units
    do_reset("t1");
    snap_q.push_back(63);
    push(0, 32'hA500_0200); push(0, 32'h0); push(0, 32'h1);
    push(0, 32'hA501_0200); push(0, 32'h10); push(1, 32'h11);
    wait_cyc(100);
    check("t1_busy", 64'(busy), 64'd0);
    check("t1_overrun", 64'(overrun_count), 64'd0);
    end_test("t1");

    // 2: backpressure on first counter across several expiries
    do_reset("t2");
    snap_q.push_back(63); snap_q.push_back(319);
    push(0, 32'hA500_0200); push(0, 32'h0); push(0, 32'h1);
    push(0, 32'hA501_0200); push(0, 32'h10); push(1, 32'h11);
    push(0, 32'hA501_0201); push(0, 32'h10); push(0, 32'h11);
    push(0, 32'hA500_0201); push(0, 32'h0); push(1, 32'h1);
    wait_cyc(67);
    out_ready = 1'b0;
    wait_cyc(130);
    check("t2_overrun_1", 64'(overrun_count), 64'd1);
    check("t2_frozen", 64'({out_valid, out_last, out_data}), 64'h1_0000_0000 << 1);
    check("t2_busy", 64'(busy), 64'd1);
    wait_cyc(200);
    check("t2_overrun_2", 64'(overrun_count), 64'd2);
    wait_cyc(267);
    check("t2_overrun_3", 64'(overrun_count), 64'd3);
    out_ready = 1'b1;
    wait_cyc(360);
    check("t2_overrun_end", 64'(overrun_count), 64'd3);
    end_test("t2");

    // 3: only unit 1 enabled, two frames
    do_reset("t3");
    unit_en = 2'b10;
    snap_q.push_back(63); snap_q.push_back(127);
    push(0, 32'hA501_0200); push(0, 32'h10); push(1, 32'h11);
    push(0, 32'hA501_0201); push(0, 32'h10); push(1, 32'h11);
    wait_cyc(170);
    end_test("t3");

    // 4: no units enabled
    do_reset("t4");
    unit_en = 2'b00;
    for (int c = 10; c <= 150; c += 10) begin
      wait_cyc(c);
      check("t4_busy", 64'(busy), 64'd0);
    end
    check("t4_overrun", 64'(overrun_count), 64'd0);
    end_test("t4");

    // 5: reset while a counter word is presented
    do_reset("t5");
    unit_en = 2'b11;
    snap_q.push_back(63);
    push(0, 32'hA500_0200); push(0, 32'h0); push(0, 32'h1); push(0, 32'hA501_0200);
    wait_cyc(76);
    @(posedge clk);
    #1;
    check("t5_pre_valid", 64'(out_valid), 64'd1);
    check("t5_pre_data", 64'(out_data), 64'h10);
    rst_n = 1'b0;
    #1;
    check_idle("t5_async");
    end_test("t5_pre");
    exp_q.delete();
    snap_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    snap_q.push_back(63);
    push(0, 32'hA500_0200); push(0, 32'h0); push(0, 32'h1);
    push(0, 32'hA501_0200); push(0, 32'h10); push(1, 32'h11);
    wait_cyc(1);
    check("t5_first_valid", 64'(out_valid), 64'd0);
    wait_cyc(100);
    end_test("t5");

    // 6: enable pause delays expiry; enable drop mid-frame
    do_reset("t6");
    unit_en = 2'b11;
    wait_cyc(19);
    enable = 1'b0;
    wait_cyc(49);
    enable = 1'b1;
    snap_q.push_back(112);
    push(0, 32'hA500_0200); push(0, 32'h0); push(0, 32'h1);
    push(0, 32'hA501_0200); push(0, 32'h10); push(1, 32'h11);
    wait_cyc(115);
    check("t6_busy_mid", 64'(busy), 64'd1);
    enable = 1'b0;
    wait_cyc(200);
    check("t6_busy_end", 64'(busy), 64'd0);
    end_test("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
